tuple_field_sequencer: RTL

- Holds a configurable table of scalar tuple fields (value plus bit width) and streams them out one field per beat over a valid/ready port, in index order.
- Sits between the constant/tuple datapath produced by the cfg front end and a downstream serial consumer, such as a dump or compare unit.
- Sequences the read-out, applies per-field width masking and skips disabled fields.

---
 rtl/tuple_field_sequencer_pkg.sv | 30 +++
 rtl/tuple_field_sequencer_if.sv | 27 ++
 rtl/tuple_field_sequencer_table.sv | 32 +++
 rtl/tuple_field_sequencer.sv | 86 ++++++++
 4 files changed

// File: rtl/tuple_field_sequencer_pkg.sv
// Shared types and helpers for the tuple field sequencer: table geometry,
// FSM states, field record and the width-to-mask helper.
package tuple_seq_pkg;

    localparam int unsigned NFIELDS = 10;
    localparam int unsigned DW      = 4;
    localparam int unsigned IW      = $clog2(NFIELDS);
    localparam int unsigned WW      = $clog2(DW + 1);

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        FIN
    } state_t;

    typedef struct packed {
        logic [DW-1:0] val;
        logic [WW-1:0] width;
    } field_t;

    // Low 'w' bits set; w is already clamped to DW by the table.
    function automatic logic [DW-1:0] width_mask(input logic [WW-1:0] w);
        logic [DW-1:0] m;
        for (int i = 0; i < DW; i++) begin
            m[i] = (i < int'(w));
        end
        return m;
    endfunction

endpackage

// File: rtl/tuple_field_sequencer_if.sv
// Config, control and streaming-beat signals of the tuple field sequencer.
interface tuple_field_sequencer_if;

    logic                        cfg_we;
    logic [tuple_seq_pkg::IW-1:0] cfg_idx;
    logic [tuple_seq_pkg::DW-1:0] cfg_val;
    logic [tuple_seq_pkg::WW-1:0] cfg_width;
    logic                        start;
    logic                        busy;
    logic                        done;
    logic                        out_valid;
    logic                        out_ready;
    logic [tuple_seq_pkg::IW-1:0] out_idx;
    logic [tuple_seq_pkg::DW-1:0] out_data;
    logic                        err;

    modport slave (
        input  cfg_we, cfg_idx, cfg_val, cfg_width, start, out_ready,
        output busy, done, out_valid, out_idx, out_data, err
    );

    modport master (
        output cfg_we, cfg_idx, cfg_val, cfg_width, start, out_ready,
        input  busy, done, out_valid, out_idx, out_data, err
    );

endinterface

// File: rtl/tuple_field_sequencer_table.sv
// NFIELDS-entry field register file: synchronous clamped write, async read.
module tuple_field_table
    import tuple_seq_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          i_we,
    input  logic [IW-1:0] i_widx,
    input  logic [DW-1:0] i_wval,
    input  logic [WW-1:0] i_wwidth,
    input  logic [IW-1:0] i_ridx,
    output field_t        o_rfield
);

    field_t        r_tab [NFIELDS];
    logic [WW-1:0] w_width_clamped;

    assign w_width_clamped = (i_wwidth > WW'(DW)) ? WW'(DW) : i_wwidth;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NFIELDS; i++) begin
                r_tab[i] <= '0;
            end
        end else if (i_we) begin
            r_tab[i_widx] <= '{val: i_wval, width: w_width_clamped};
        end
    end

    assign o_rfield = r_tab[i_ridx];

endmodule

// File: rtl/tuple_field_sequencer.sv
// Streams enabled table fields one per beat in index order over valid/ready,
// masking each value to its configured width and skipping disabled fields.
module tuple_field_sequencer
    import tuple_seq_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    tuple_field_sequencer_if.slave  bus
);

    state_t        r_state, w_state_nxt;
    logic [IW-1:0] r_ptr, w_ptr_nxt;
    logic          r_err, w_err_nxt;
    logic          w_we;
    logic          w_valid;
    logic          w_last;
    field_t        w_field;

    tuple_field_table u_table (
        .clock    (clock),
        .reset    (reset),
        .i_we     (w_we),
        .i_widx   (bus.cfg_idx),
        .i_wval   (bus.cfg_val),
        .i_wwidth (bus.cfg_width),
        .i_ridx   (r_ptr),
        .o_rfield (w_field)
    );

    assign w_last = (r_ptr == IW'(NFIELDS - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_err_nxt   = 1'b0;
        w_we        = 1'b0;
        w_valid     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.cfg_we) begin
                    if (32'(bus.cfg_idx) < NFIELDS) w_we = 1'b1;
                    else                            w_err_nxt = 1'b1;
                end
                if (bus.start) begin
                    w_state_nxt = EMIT;
                    w_ptr_nxt   = '0;
                end
            end
            EMIT: begin
                w_err_nxt = bus.cfg_we | bus.start;
                w_valid   = (w_field.width != '0);
                // Disabled fields cost exactly one bubble cycle.
                if (!w_valid || bus.out_ready) begin
                    if (w_last) w_state_nxt = FIN;
                    else        w_ptr_nxt   = r_ptr + 1'b1;
                end
            end
            FIN: begin
                w_err_nxt   = bus.cfg_we | bus.start;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Outputs depend only on state registers and table contents, never on out_ready.
    assign bus.busy      = (r_state == EMIT);
    assign bus.done      = (r_state == FIN);
    assign bus.out_valid = w_valid;
    assign bus.out_idx   = w_valid ? r_ptr : '0;
    assign bus.out_data  = w_valid ? (w_field.val & width_mask(w_field.width)) : '0;
    assign bus.err       = r_err;

endmodule
